sim_halt_monitor: RTL and testbench
===================================

SIM_HALT_MONITOR -- requirements
Module: sim_halt_monitor

Interface
REQ-001 Parameter NUM_HARTS, default 1, number of monitored harts (1..8).
REQ-002 Parameter XLEN, default 32, width of each hart's a0 value.
REQ-003 Parameter CNT_W, default 32, width of cycle and instret counters.
REQ-004 Parameter TIMEOUT, default 10000000, run-cycle limit (1..2^CNT_W-1).
REQ-005 Parameter DRAIN_CYCLES, default 2, settle cycles between the stop condition and done (0..15).
REQ-006 Parameter HALT_ALL, default 0; 0 = stop when any hart halts, 1 = stop when all harts have halted.
REQ-007 clk  input  1  clock, all state on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 ebreak  input  NUM_HARTS  per-hart ebreak-commit indication, sampled every cycle.
REQ-010 a0  input  NUM_HARTS*XLEN  per-hart a0; hart i at bits [i*XLEN +: XLEN].
REQ-011 commit  input  NUM_HARTS  per-hart instruction-retire strobe.
REQ-012 cycle_count  output  CNT_W  run cycles elapsed.
REQ-013 halted  output  NUM_HARTS  sticky per-hart halt flags.
REQ-014 bad_mask  output  NUM_HARTS  sticky per-hart nonzero-a0-at-halt flags.
REQ-015 done  output  1  sticky end-of-simulation flag.
REQ-016 status  output  2  00 running, 01 GOOD, 10 BAD, 11 TIMEOUT.
REQ-017 instret  output  NUM_HARTS*CNT_W  per-hart retired counts, hart i at [i*CNT_W +: CNT_W].

Function
REQ-018 FSM states RUN, DRAIN, DONE; state after reset is RUN.
REQ-019 RUN: cycle_count increments by 1 every cycle; it is frozen in DRAIN and DONE; no wrap (TIMEOUT bound guarantees).
REQ-020 Halt capture: in RUN or DRAIN, when ebreak[i]=1 and halted[i]=0, next cycle halted[i]=1 and bad_mask[i]=(a0[i]!=0); a0 is sampled in the same cycle as ebreak.
REQ-021 Repeated ebreak on an already halted hart has no effect; ebreak is ignored in DONE.
REQ-022 Stop condition: HALT_ALL=0 -> OR of (halted | ebreak); HALT_ALL=1 -> AND of (halted | ebreak).
REQ-023 Timeout condition: in RUN, cycle_count == TIMEOUT-1.
REQ-024 RUN -> DRAIN on stop or timeout (-> DONE directly if DRAIN_CYCLES=0); reason latched at transition.
REQ-025 Halt and timeout in the same cycle: halt reason wins.
REQ-026 DRAIN lasts exactly DRAIN_CYCLES cycles, then DONE; additional hart halts during DRAIN are still captured.
REQ-027 Entering DONE: done=1; status = TIMEOUT if reason was timeout, else BAD if bad_mask!=0, else GOOD; all outputs then held until reset.
REQ-028 status reads 00 and done reads 0 in RUN and DRAIN.

Reset
REQ-029 reset in any state, including DRAIN or DONE, returns next cycle to RUN with cycle_count=0, halted=0, bad_mask=0, done=0, status=00, instret=0.
REQ-030 While reset is high, ebreak, commit and a0 are ignored.

Configuration
REQ-031 Macro SIM_MONITOR_INSTRET_EN defined: instret[i] increments by 1 on each cycle commit[i]=1 in RUN or DRAIN, saturating at all-ones, frozen in DONE.
REQ-032 Macro undefined: no instret counters are built; instret is driven to constant 0 and commit is unused.

Verification
REQ-033 NUM_HARTS=1, reset 5 cycles, ebreak=1 with a0=0 on run cycle 100 -> cycle_count 100, done after 2 more cycles, status 01.
REQ-034 Same with a0=0x0000_0001 -> bad_mask=1, status 10, cycle_count 100.
REQ-035 TIMEOUT=50, no ebreak -> cycle_count 49 frozen, done 2 cycles later, status 11; ebreak at cycle 49 instead -> status 01.
REQ-036 NUM_HARTS=2, HALT_ALL=1: hart0 ebreak a0=0 at cycle 10, hart1 ebreak a0=3 at cycle 20 -> halted=11 at cycle 21, bad_mask=10, status 10; with HALT_ALL=0, hart1 ebreak at cycle 11 (in DRAIN) -> still captured, status 10.
REQ-037 Reset asserted for 1 cycle in DRAIN -> all outputs 0, status 00, counting restarts from 0.
REQ-038 SIM_MONITOR_INSTRET_EN defined, commit=1 every other cycle for 40 run cycles then ebreak -> instret=20; macro undefined -> instret=0.

Source files
------------

// File: rtl/sim_halt_monitor.sv
// End-of-simulation monitor: captures per-hart ebreak halts and judges the run GOOD/BAD/TIMEOUT.
// Optional macro SIM_MONITOR_INSTRET_EN builds per-hart saturating retired-instruction counters.

module sim_halt_hart #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active,
    input  logic             ebreak,
    input  logic [XLEN-1:0]  a0,
`ifdef SIM_MONITOR_INSTRET_EN
    input  logic             commit,
`endif
    output logic             halted,
    output logic             bad,
    output logic             bad_next,
    output logic [CNT_W-1:0] instret
);

    logic take;

    // Only the first ebreak of a hart counts; a0 is judged in that same cycle.
    assign take     = active && ebreak && !halted;
    assign bad_next = take ? (a0 != '0) : bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            halted <= 1'b0;
            bad    <= 1'b0;
        end else begin
            if (take)
                halted <= 1'b1;
            bad <= bad_next;
        end
    end

`ifdef SIM_MONITOR_INSTRET_EN
    always_ff @(posedge clk) begin
        if (reset)
            instret <= '0;
        else if (active && commit && (instret != '1))
            instret <= instret + CNT_W'(1);
    end
`else
    assign instret = '0;
`endif

endmodule

module sim_halt_monitor #(
    parameter int     NUM_HARTS    = 1,
    parameter int     XLEN         = 32,
    parameter int     CNT_W        = 32,
    parameter longint TIMEOUT      = 10000000,
    parameter int     DRAIN_CYCLES = 2,
    parameter int     HALT_ALL     = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_HARTS-1:0]       ebreak,
    input  logic [NUM_HARTS*XLEN-1:0]  a0,
    input  logic [NUM_HARTS-1:0]       commit,
    output logic [CNT_W-1:0]           cycle_count,
    output logic [NUM_HARTS-1:0]       halted,
    output logic [NUM_HARTS-1:0]       bad_mask,
    output logic                       done,
    output logic [1:0]                 status,
    output logic [NUM_HARTS*CNT_W-1:0] instret
);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    localparam logic [1:0] ST_GOOD    = 2'b01;
    localparam logic [1:0] ST_BAD     = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       DRAIN_LAST   = 4'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);

    state_t                 state, state_next;
    logic [3:0]             drain_cnt, drain_cnt_next;
    logic                   timeout_reason, reason_next;
    logic                   active;
    logic                   stop;
    logic                   timeout_hit;
    logic [NUM_HARTS-1:0]   bad_next;
    logic [NUM_HARTS-1:0]   halt_view;

    assign active      = (state != DONE);
    assign halt_view   = halted | ebreak;
    assign timeout_hit = (state == RUN) && (cycle_count == TIMEOUT_LAST);

    generate
        if (HALT_ALL != 0) begin : g_stop_all
            assign stop = &halt_view;
        end else begin : g_stop_any
            assign stop = |halt_view;
        end
    endgenerate

    for (genvar i = 0; i < NUM_HARTS; i++) begin : g_hart
        sim_halt_hart #(
            .XLEN  (XLEN),
            .CNT_W (CNT_W)
        ) u_hart (
            .clk      (clk),
            .reset    (reset),
            .active   (active),
            .ebreak   (ebreak[i]),
            .a0       (a0[i*XLEN +: XLEN]),
`ifdef SIM_MONITOR_INSTRET_EN
            .commit   (commit[i]),
`endif
            .halted   (halted[i]),
            .bad      (bad_mask[i]),
            .bad_next (bad_next[i]),
            .instret  (instret[i*CNT_W +: CNT_W])
        );
    end

`ifndef SIM_MONITOR_INSTRET_EN
    logic unused_commit;
    assign unused_commit = ^commit;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            drain_cnt      <= '0;
            timeout_reason <= 1'b0;
        end else begin
            state          <= state_next;
            drain_cnt      <= drain_cnt_next;
            timeout_reason <= reason_next;
        end
    end

    // Halt beats timeout when both arrive in the same cycle.
    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        reason_next    = timeout_reason;
        case (state)
            RUN: begin
                drain_cnt_next = '0;
                if (stop || timeout_hit) begin
                    reason_next = !stop;
                    state_next  = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                drain_cnt_next = drain_cnt + 4'd1;
                if (drain_cnt == DRAIN_LAST)
                    state_next = DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            cycle_count <= '0;
        else if (state == RUN && state_next == RUN)
            cycle_count <= cycle_count + CNT_W'(1);
    end

    // Verdict uses bad_next so a halt captured on the final edge still counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            done   <= 1'b0;
            status <= 2'b00;
        end else if (state != DONE && state_next == DONE) begin
            done <= 1'b1;
            if (reason_next)
                status <= ST_TIMEOUT;
            else if (|bad_next)
                status <= ST_BAD;
            else
                status <= ST_GOOD;
        end
    end

endmodule

// File: tb/tb_sim_halt_monitor.sv
// Directed bench for sim_halt_monitor: table of single-hart runs plus hand-written
// multi-hart, drain-capture and reset-in-drain sequences.

module tb_sim_halt_monitor;

`ifdef SIM_MONITOR_INSTRET_EN
    localparam bit IR_ON = 1'b1;
`else
    localparam bit IR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // single-hart group (a: long timeout, b: TIMEOUT=50)
    logic        rst1;
    logic [0:0]  ebreak1, commit1;
    logic [31:0] a0_1;
    logic [31:0] cc_a, cc_b, ir_a, ir_b;
    logic [0:0]  halted_a, halted_b, bad_a, bad_b;
    logic        done_a, done_b;
    logic [1:0]  st_a, st_b;

    // two-hart group (c: HALT_ALL=1, d: HALT_ALL=0)
    logic        rst2;
    logic [1:0]  ebreak2, commit2;
    logic [63:0] a0_2;
    logic [31:0] cc_c, cc_d;
    logic [63:0] ir_c, ir_d;
    logic [1:0]  halted_c, halted_d, bad_c, bad_d;
    logic        done_c, done_d;
    logic [1:0]  st_c, st_d;

    sim_halt_monitor #(.NUM_HARTS(1)) dut_a (
        .clk(clk), .reset(rst1), .ebreak(ebreak1), .a0(a0_1), .commit(commit1),
        .cycle_count(cc_a), .halted(halted_a), .bad_mask(bad_a), .done(done_a),
        .status(st_a), .instret(ir_a));

    sim_halt_monitor #(.NUM_HARTS(1), .TIMEOUT(50)) dut_b (
        .clk(clk), .reset(rst1), .ebreak(ebreak1), .a0(a0_1), .commit(commit1),
        .cycle_count(cc_b), .halted(halted_b), .bad_mask(bad_b), .done(done_b),
        .status(st_b), .instret(ir_b));

    sim_halt_monitor #(.NUM_HARTS(2), .HALT_ALL(1)) dut_c (
        .clk(clk), .reset(rst2), .ebreak(ebreak2), .a0(a0_2), .commit(commit2),
        .cycle_count(cc_c), .halted(halted_c), .bad_mask(bad_c), .done(done_c),
        .status(st_c), .instret(ir_c));

    sim_halt_monitor #(.NUM_HARTS(2), .HALT_ALL(0)) dut_d (
        .clk(clk), .reset(rst2), .ebreak(ebreak2), .a0(a0_2), .commit(commit2),
        .cycle_count(cc_d), .halted(halted_d), .bad_mask(bad_d), .done(done_d),
        .status(st_d), .instret(ir_d));

    bit          sel;
    logic [31:0] cc1, ir1;
    logic        halted1, bad1, done1;
    logic [1:0]  st1;
    assign cc1     = sel ? cc_b     : cc_a;
    assign ir1     = sel ? ir_b     : ir_a;
    assign halted1 = sel ? halted_b[0] : halted_a[0];
    assign bad1    = sel ? bad_b[0] : bad_a[0];
    assign done1   = sel ? done_b   : done_a;
    assign st1     = sel ? st_b     : st_a;

    typedef struct {
        bit          inst;
        bit          eb;
        int          kend;
        logic [31:0] a0;
        int          cmode;
        logic [31:0] exp_cc;
        bit          exp_halt;
        bit          exp_bad;
        logic [1:0]  exp_st;
        logic [31:0] exp_ir;
    } vec_t;

    vec_t vecs[8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int waited;
        sel     = v.inst;
        ebreak1 = 1'b0;
        a0_1    = '0;
        commit1 = 1'b0;
        rst1    = 1'b1;
        repeat (5) tick();
        chk($sformatf("v%0d_reset_cnt", idx), {cc1, ir1}, 64'h0);
        chk($sformatf("v%0d_reset_flags", idx), {halted1, bad1, done1, st1}, 64'h0);
        rst1 = 1'b0;
        for (int k = 0; k <= v.kend; k++) begin
            ebreak1 = v.eb && (k == v.kend);
            a0_1    = (k == v.kend) ? v.a0 : ~v.a0;
            commit1 = (v.cmode == 1) ? ((k < 40) && (k % 2 == 0)) : (v.cmode == 2);
            tick();
        end
        ebreak1 = 1'b0;
        a0_1    = '0;
        commit1 = (v.cmode == 2);
        waited  = 0;
        while (!done1 && waited < 20) begin
            chk($sformatf("v%0d_drain_state", idx), {st1, cc1}, {2'b00, v.exp_cc});
            tick();
            waited++;
        end
        chk($sformatf("v%0d_drain_len", idx), 64'(waited), 64'd2);
        chk($sformatf("v%0d_cycle_count", idx), 64'(cc1), 64'(v.exp_cc));
        chk($sformatf("v%0d_halted", idx), 64'(halted1), 64'(v.exp_halt));
        chk($sformatf("v%0d_bad_mask", idx), 64'(bad1), 64'(v.exp_bad));
        chk($sformatf("v%0d_status", idx), 64'(st1), 64'(v.exp_st));
        chk($sformatf("v%0d_done", idx), 64'(done1), 64'd1);
        chk($sformatf("v%0d_instret", idx), 64'(ir1), 64'(v.exp_ir));
        // everything must stay put in DONE despite fresh stimulus
        ebreak1 = 1'b1;
        a0_1    = '1;
        commit1 = 1'b1;
        repeat (3) tick();
        ebreak1 = 1'b0;
        commit1 = 1'b0;
        chk($sformatf("v%0d_hold_cnt", idx), {cc1, ir1}, {v.exp_cc, v.exp_ir});
        chk($sformatf("v%0d_hold_flags", idx), {halted1, bad1, done1, st1},
            {v.exp_halt, v.exp_bad, 1'b1, v.exp_st});
    endtask

    initial begin
        rst1 = 1'b1; ebreak1 = '0; commit1 = '0; a0_1 = '0;
        rst2 = 1'b1; ebreak2 = '0; commit2 = '0; a0_2 = '0;
        sel  = 1'b0;

        //          inst eb   kend a0            cmode cc   halt bad st     instret
        vecs[0] = '{1'b0, 1'b1, 100, 32'h0,        0, 100, 1'b1, 1'b0, 2'b01, 32'd0};
        vecs[1] = '{1'b0, 1'b1, 100, 32'h1,        0, 100, 1'b1, 1'b1, 2'b10, 32'd0};
        vecs[2] = '{1'b1, 1'b0, 49,  32'h0,        0, 49,  1'b0, 1'b0, 2'b11, 32'd0};
        vecs[3] = '{1'b1, 1'b1, 49,  32'h0,        0, 49,  1'b1, 1'b0, 2'b01, 32'd0};
        vecs[4] = '{1'b1, 1'b1, 49,  32'h8000_0000, 0, 49, 1'b1, 1'b1, 2'b10, 32'd0};
        vecs[5] = '{1'b0, 1'b1, 40,  32'h0,        1, 40,  1'b1, 1'b0, 2'b01, IR_ON ? 32'd20 : 32'd0};
        vecs[6] = '{1'b1, 1'b1, 0,   32'h5,        0, 0,   1'b1, 1'b1, 2'b10, 32'd0};
        vecs[7] = '{1'b0, 1'b1, 3,   32'hFFFF_FFFF, 2, 3,  1'b1, 1'b1, 2'b10, IR_ON ? 32'd6 : 32'd0};

        for (int i = 0; i < 8; i++)
            run_vec(i, vecs[i]);

        // reset for one cycle while in DRAIN; ebreak/commit during reset are ignored
        sel  = 1'b0;
        rst1 = 1'b1;
        repeat (5) tick();
        rst1 = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            ebreak1 = (k == 5);
            a0_1    = 32'h1;
            commit1 = 1'b1;
            tick();
        end
        chk("rst_drain_pre", {done1, st1, cc1}, {1'b0, 2'b00, 32'd5});
        rst1    = 1'b1;
        ebreak1 = 1'b1;
        commit1 = 1'b1;
        tick();
        rst1    = 1'b0;
        ebreak1 = 1'b0;
        commit1 = 1'b0;
        chk("rst_drain_cnt", {cc1, ir1}, 64'h0);
        chk("rst_drain_flags", {halted1, bad1, done1, st1}, 64'h0);
        repeat (7) tick();
        chk("rst_drain_restart", {done1, st1, cc1}, {1'b0, 2'b00, 32'd7});

        // HALT_ALL=1: both harts must halt; re-ebreak of a halted hart is ignored
        rst2 = 1'b1;
        repeat (5) tick();
        rst2 = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            ebreak2 = (k == 10 || k == 15) ? 2'b01 : (k == 20) ? 2'b10 : 2'b00;
            a0_2    = (k == 10) ? {32'hDEAD, 32'h0} :
                      (k == 15) ? {32'h0, 32'h7} :
                      (k == 20) ? {32'h3, 32'hFFFF} : {32'h1, 32'h1};
            tick();
            if (k == 10)
                chk("all_first_halt", {done_c, halted_c, cc_c}, {1'b0, 2'b01, 32'd11});
            if (k == 15)
                chk("all_rehalt_ignored", {done_c, halted_c, bad_c}, {1'b0, 2'b01, 2'b00});
        end
        ebreak2 = 2'b00;
        chk("all_both_halted", {halted_c, bad_c, cc_c}, {2'b11, 2'b10, 32'd20});
        tick();
        tick();
        chk("all_done", {done_c, st_c}, {1'b1, 2'b10});

        // HALT_ALL=0: second hart halting during DRAIN is still captured
        rst2 = 1'b1;
        repeat (5) tick();
        rst2 = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            ebreak2 = (k == 10) ? 2'b01 : 2'b00;
            a0_2    = (k == 10) ? {32'h9, 32'h0} : {32'h1, 32'h1};
            tick();
        end
        ebreak2 = 2'b10;
        a0_2    = {32'h3, 32'h0};
        tick();
        ebreak2 = 2'b00;
        chk("any_drain_capture", {done_d, halted_d, bad_d, cc_d}, {1'b0, 2'b11, 2'b10, 32'd10});
        tick();
        chk("any_done", {done_d, st_d}, {1'b1, 2'b10});
        chk("any_instret", ir_d, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
